stream_demux_n: RTL
===================

Name: stream_demux_n

Overview:
- Parametrised successor to the team's 1-to-4 combinational demux.
- Routes a single valid/ready input stream to one of NCH output channels, or to all channels at once in broadcast mode.
- Each channel has a one-entry registered output stage with independent back-pressure.
- Sits between a stream producer and NCH consumers; one cycle of latency; full throughput per channel.

Parameters:
- W, 8, data width in bits.
- NCH, 4, number of output channels (2..16).
- SELW, 2, width of the select input; must satisfy 2^SELW >= NCH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  W  input word.
- in_sel  input  SELW  destination channel index (unicast).
- in_bcast  input  1  1 = deliver the word to every channel; in_sel is ignored.
- out_valid  output  NCH  per-channel word present; bit c belongs to channel c.
- out_ready  input  NCH  per-channel consumer ready.
- out_data  output  NCH*W  channel c occupies bits [c*W +: W].
- err  output  1  sticky flag: a unicast word with out-of-range select was dropped.
- cnt  output  NCH*16  per-channel delivered-word counters; channel c occupies bits [c*16 +: 16]. See Optional Feature.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, err=0, cnt=0. Words held in channel registers are discarded.
- Reset mid-operation: a pending word is lost; no handshake completes in the reset cycle. in_ready is forced to 0 while rst=1.
- Per-channel state: full[c] (mirrored on out_valid[c]) and data register.
- Channel handshake: out_valid[c] && out_ready[c]. It clears full[c] unless the channel is reloaded in the same cycle.
- free[c] = !full[c] || out_ready[c].
- in_ready is combinational:
  - in_bcast=1: AND of free[0..NCH-1].
  - in_bcast=0, in_sel<NCH: free[in_sel].
  - in_bcast=0, in_sel>=NCH: 1.
- in_ready depends only on state, out_ready, in_sel and in_bcast; it never depends on in_valid.
- Accept = in_valid && in_ready.
- Unicast accept: load in_data into channel in_sel and set full. All other channels are unaffected.
- Broadcast accept: load in_data into all channels and set all full bits in the same cycle. A broadcast never partially delivers.
- Out-of-range unicast (in_sel>=NCH): the word is accepted and dropped, and err is set. err stays 1 until rst.
- Latency: a word accepted at edge n gives out_valid=1 with that data after edge n.
- Throughput: simultaneous drain and reload of the same channel is allowed. One word per cycle is sustained when out_ready is held high.
- Stability: while out_valid[c]=1 and out_ready[c]=0, out_data[c] holds its value.
- Idle channels: when out_valid[c]=0, out_data[c] keeps its last value. Consumers must not sample it.
- Ordering: per-channel order is preserved. There is no ordering guarantee across channels.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt[c] increments on each channel-c output handshake.
  - The counter is 16 bits and wraps from 16'hFFFF to 0.
  - A broadcast counts once per channel, as each channel's handshake completes.
- Undefined: cnt port remains present and is tied to 0; no counter logic is built.

Test Plan:
1. Reset/idle: NCH=4. Assert rst for 2 cycles with in_valid=1 → out_valid=4'b0000, err=0, in_ready=0 during reset, cnt=0.
2. Unicast streaming: out_ready=4'b1111; send 8'hA0..8'hA3 with sel 0,1,2,3 back-to-back → each appears one cycle later on its own channel only; in_ready stays 1 throughout.
3. Back-pressure: out_ready[2]=0; send 8'h11 then 8'h22 to channel 2 → 8'h11 held on channel 2 and in_ready=0 while sel=2. A sel=1 word is still accepted. Raise out_ready[2] → 8'h22 is delivered the next cycle.
4. Broadcast: out_ready=4'b1011, one channel full, in_bcast=1, data 8'h5A → in_ready=0 until channel 2 drains. Then all four channels show 8'h5A in the same cycle.
5. Out-of-range: NCH=3, SELW=2, sel=2'b11, data 8'hFF → in_ready=1, no out_valid rises, err=1 and remains 1 until rst.
6. Counters (DEMUX_CNT_EN): 65537 handshakes on channel 0 → cnt[0]=1 and other channels read 0. Without the macro → cnt=0 for the same stimulus.

Source files
------------

// File: rtl/stream_demux_n.sv
// One-to-NCH valid/ready stream demux with a registered one-entry stage per channel,
// broadcast mode and a sticky out-of-range error. Define DEMUX_CNT_EN to build per-channel handshake counters.
module stream_demux_n #(
  parameter int W    = 8,
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic              in_bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*W-1:0]  out_data,
  output logic              err,
  output logic [NCH*16-1:0] cnt
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] free;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] load;
  logic [W-1:0]   data_q [NCH];
  logic           sel_ok;
  logic           accept;

  always_comb begin
    free   = ~full | out_ready;
    sel_ok = (32'(in_sel) < 32'(NCH));
    for (int unsigned c = 0; c < NCH; c++) begin
      hit[c] = (32'(in_sel) == c);
    end
    // Out-of-range unicast is always accepted so the word can be dropped.
    if (rst)           in_ready = 1'b0;
    else if (in_bcast) in_ready = &free;
    else if (sel_ok)   in_ready = |(free & hit);
    else               in_ready = 1'b1;
    accept = in_valid && in_ready;
    load   = '0;
    if (accept) load = in_bcast ? '1 : hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      err  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        data_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (load[c]) begin
          full[c]   <= 1'b1;
          data_q[c] <= in_data;
        end else if (out_ready[c]) begin
          full[c] <= 1'b0;
        end
      end
      if (accept && !in_bcast && !sel_ok) err <= 1'b1;
    end
  end

  assign out_valid = full;

  always_comb begin
    out_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      out_data[c*W +: W] = data_q[c];
    end
  end

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_q [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (full[c] && out_ready[c]) cnt_q[c] <= cnt_q[c] + 16'd1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      cnt[c*16 +: 16] = cnt_q[c];
    end
  end
`else
  assign cnt = '0;
`endif

endmodule
